puf_challenge_seq: RTL and testbench
====================================

PUF_CHALLENGE_SEQ -- requirements
Module: puf_challenge_seq

Interface
REQ-001 Parameter N, default 128: challenge width, equal to the arbiter PUF stage count.
REQ-002 Parameter SETTLE, default 4: cycles puf_in is held high before sampling; legal values are 2 or more.
REQ-003 Parameter VOTES, default 5: evaluations per challenge; legal values are odd and 1 or more.
REQ-004 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req_valid, input, 1 bit: a challenge request is present.
REQ-007 Port req_ready, output, 1 bit: the block accepts a request.
REQ-008 Port req_challenge, input, N bits: challenge presented with the request.
REQ-009 Port puf_sel, output, N bits: challenge driven to the arbiter PUF.
REQ-010 Port puf_in, output, 1 bit: launch signal to the PUF delay lines.
REQ-011 Port puf_rst, output, 1 bit: active-high clear of the PUF arbiter latch.
REQ-012 Port puf_out, input, 1 bit: raw PUF response, asynchronous to clk.
REQ-013 Port rsp_valid, output, 1 bit: a response is available.
REQ-014 Port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-015 Port rsp_bit, output, 1 bit: majority-voted response.
REQ-016 Port rsp_ones, output, clog2(VOTES+1) bits: number of evaluations that returned 1.
REQ-017 Port rsp_stable, output, 1 bit: all VOTES evaluations agreed.

Function
REQ-018 FSM states: IDLE, CLEAR, LAUNCH, SETTLE, SAMPLE, DONE; all outputs are registered.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1.
REQ-020 On accept, req_challenge SHALL be latched into puf_sel, the vote counter and ones counter SHALL clear, and the FSM SHALL go IDLE -> CLEAR.
REQ-021 puf_sel SHALL change only on accept and hold its value otherwise, including in IDLE and DONE.
REQ-022 CLEAR lasts 1 cycle with puf_rst=1 and puf_in=0.
REQ-023 LAUNCH lasts 1 cycle with puf_rst=0 and puf_in=1; this is exactly one rising edge of puf_in per evaluation.
REQ-024 SETTLE lasts SETTLE cycles with puf_rst=0 and puf_in=1.
REQ-025 SAMPLE lasts 1 cycle with puf_in=1; it captures puf_out_sync, increments rsp_ones if the captured value is 1, and increments the vote count.
REQ-026 After SAMPLE: if vote count is less than VOTES, go to CLEAR; otherwise go to DONE.
REQ-027 puf_out SHALL pass through a 2-flop synchronizer before use; SETTLE of 2 or more covers the synchronizer delay.
REQ-028 In IDLE and DONE, puf_rst=1 and puf_in=0.
REQ-029 Each evaluation takes SETTLE+3 cycles; rsp_valid SHALL rise exactly VOTES*(SETTLE+3) edges after the accept edge (35 cycles at the defaults).
REQ-030 In DONE, rsp_valid=1; rsp_bit = 1 when rsp_ones is greater than VOTES/2 (integer division); rsp_stable = 1 when rsp_ones is 0 or equals VOTES.
REQ-031 rsp_bit, rsp_ones and rsp_stable SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-032 When DONE and rsp_ready=1: go to IDLE and drop rsp_valid on that edge; req_ready SHALL rise at that same edge, with no same-cycle accept bypass.
REQ-033 req_valid and req_challenge SHALL be ignored while not in IDLE.
REQ-034 rsp_ones SHALL not wrap: its width holds VOTES exactly.

Reset
REQ-035 While reset=0, asynchronously: state=IDLE, puf_sel=0, puf_in=0, puf_rst=1, rsp_valid=0, rsp_bit=0, rsp_ones=0, rsp_stable=0, req_ready=0, synchronizer flops=0.
REQ-036 req_ready SHALL go to 1 on the first clk edge after reset rises.
REQ-037 Reset asserted in any state aborts the operation; no response is produced for the in-flight request.

Verification
REQ-038 Assert reset in mid-SETTLE -> puf_in=0, puf_rst=1, puf_sel=0, rsp_valid=0 without a clock edge; req_ready=1 one edge after release.
REQ-039 Defaults, puf_out held at 1, challenge all 0xA5 -> exactly 5 puf_in rising edges; rsp_valid at cycle 35; rsp_bit=1, rsp_ones=5, rsp_stable=1.
REQ-040 puf_out per evaluation 1,0,1,0,0 -> rsp_bit=0, rsp_ones=2, rsp_stable=0.
REQ-041 rsp_ready held at 0 for 10 cycles in DONE with req_valid=1 -> response fields constant and req_ready=0; rsp_ready=1 -> IDLE, and next request accepted at the following edge.
REQ-042 req_challenge toggled every cycle during an operation -> puf_sel equals the accepted value until the next accept.
REQ-043 Two back-to-back requests with rsp_ready tied to 1 -> second accept occurs 1 edge after the first response handshake; second rsp_valid occurs 35 edges after that accept.

Source files
------------

// File: rtl/puf_challenge_seq.sv
// Challenge sequencer for an arbiter PUF: repeats clear/launch/settle/sample
// VOTES times per request and returns a majority-voted response bit.
module puf_challenge_seq #(
  parameter int N      = 128,
  parameter int SETTLE = 4,
  parameter int VOTES  = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [N-1:0]                 req_challenge,
  output logic [N-1:0]                 puf_sel,
  output logic                         puf_in,
  output logic                         puf_rst,
  input  logic                         puf_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_bit,
  output logic [$clog2(VOTES+1)-1:0]   rsp_ones,
  output logic                         rsp_stable
);

  localparam int CW = $clog2(VOTES + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_accept;
  logic            w_sample;
  logic            r_sync1;
  logic            r_sync2;
  logic [SW-1:0]   r_settle_cnt;
  logic [CW-1:0]   r_votes;
  logic [CW-1:0]   r_ones;
  logic [CW-1:0]   w_votes_next;
  logic [CW-1:0]   w_ones_next;
  logic [N-1:0]    r_puf_sel;
  logic            r_puf_in;
  logic            r_puf_rst;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic            r_rsp_bit;
  logic            r_rsp_stable;

  assign w_votes_next = r_votes + CW'(1);
  assign w_ones_next  = r_ones + CW'(r_sync2);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // req_ready is still low on the first cycle out of reset, so no accept then
        if (req_valid && r_req_ready) begin
          w_accept     = 1'b1;
          w_state_next = S_CLEAR;
        end
      end
      S_CLEAR:  w_state_next = S_LAUNCH;
      S_LAUNCH: w_state_next = S_SETTLE;
      S_SETTLE: begin
        if (r_settle_cnt == SW'(SETTLE - 1)) begin
          w_state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_sample = 1'b1;
        if (w_votes_next >= CW'(VOTES)) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_CLEAR;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= puf_out;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_votes      <= '0;
      r_ones       <= '0;
      r_puf_sel    <= '0;
      r_puf_in     <= 1'b0;
      r_puf_rst    <= 1'b1;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_bit    <= 1'b0;
      r_rsp_stable <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (r_state == S_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + SW'(1);
      end else begin
        r_settle_cnt <= '0;
      end

      if (w_accept) begin
        r_puf_sel    <= req_challenge;
        r_votes      <= '0;
        r_ones       <= '0;
        r_rsp_bit    <= 1'b0;
        r_rsp_stable <= 1'b0;
      end else if (w_sample) begin
        r_votes <= w_votes_next;
        r_ones  <= w_ones_next;
        // Verdict uses the count including this final vote
        if (w_state_next == S_DONE) begin
          r_rsp_bit    <= (w_ones_next > CW'(VOTES / 2));
          r_rsp_stable <= (w_ones_next == '0) || (w_ones_next == CW'(VOTES));
        end
      end

      // Outputs are decoded from the next state so they line up with it
      r_req_ready <= (w_state_next == S_IDLE);
      r_rsp_valid <= (w_state_next == S_DONE);
      r_puf_in    <= (w_state_next == S_LAUNCH) || (w_state_next == S_SETTLE) ||
                     (w_state_next == S_SAMPLE);
      r_puf_rst   <= (w_state_next == S_IDLE) || (w_state_next == S_CLEAR) ||
                     (w_state_next == S_DONE);
    end
  end

  assign req_ready  = r_req_ready;
  assign puf_sel    = r_puf_sel;
  assign puf_in     = r_puf_in;
  assign puf_rst    = r_puf_rst;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_bit    = r_rsp_bit;
  assign rsp_ones   = r_ones;
  assign rsp_stable = r_rsp_stable;

endmodule

// File: tb/tb_puf_challenge_seq.sv
// Bench for puf_challenge_seq: directed and random requests checked against
// a vote-count model of the expected response and its timing.
module tb_puf_challenge_seq;

  localparam int N      = 128;
  localparam int SETTLE = 4;
  localparam int VOTES  = 5;
  localparam int LAT    = VOTES * (SETTLE + 3);
  localparam int CW     = $clog2(VOTES + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [N-1:0]  req_challenge = '0;
  logic [N-1:0]  puf_sel;
  logic          puf_in;
  logic          puf_rst;
  logic          puf_out = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_bit;
  logic [CW-1:0] rsp_ones;
  logic          rsp_stable;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;
  int eval_idx = 0;
  int pin_edges = 0;
  logic [VOTES-1:0] pat_g = '0;

  puf_challenge_seq #(.N(N), .SETTLE(SETTLE), .VOTES(VOTES)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_challenge (req_challenge),
    .puf_sel       (puf_sel),
    .puf_in        (puf_in),
    .puf_rst       (puf_rst),
    .puf_out       (puf_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_bit       (rsp_bit),
    .rsp_ones      (rsp_ones),
    .rsp_stable    (rsp_stable)
  );

  always #5 clk = ~clk;

  // Behaves as the PUF: each launch picks the next response from the pattern
  initial begin
    forever begin
      @(posedge puf_in);
      puf_out = pat_g[eval_idx % VOTES];
      eval_idx++;
      pin_edges++;
    end
  end

  task automatic check_val(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N-1:0] rand_ch();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge with the block idle; returns at the negedge after the handshake
  task automatic run_txn(input logic [N-1:0] ch, input logic [VOTES-1:0] pat,
                         input int hold, input bit toggle);
    int ones;
    logic ebit;
    logic estable;
    ones    = $countones(pat);
    ebit    = (ones > VOTES / 2);
    estable = (ones == 0) || (ones == VOTES);

    check_val("req_ready_idle", req_ready, 1);
    pat_g         = pat;
    req_valid     = 1'b1;
    req_challenge = ch;
    rsp_ready     = (hold == 0);
    @(posedge clk);
    eval_idx  = 0;
    pin_edges = 0;
    @(negedge clk);
    req_valid = 1'b0;
    check_val("busy_ready", req_ready, 0);
    check_val("early_valid", rsp_valid, 0);
    for (int k = 1; k <= LAT; k++) begin
      if (toggle) begin
        req_valid     = 1'($urandom);
        req_challenge = rand_ch();
      end
      @(posedge clk);
      @(negedge clk);
      check_val("rsp_valid_time", rsp_valid, (k == LAT) ? 1 : 0);
      check_val("puf_sel_hold", puf_sel, ch);
      check_val("ready_busy", req_ready, 0);
    end
    check_val("rsp_ones", rsp_ones, ones);
    check_val("rsp_bit", rsp_bit, ebit);
    check_val("rsp_stable", rsp_stable, estable);
    check_val("launch_edges", pin_edges, VOTES);
    if (hold > 0) begin
      req_valid     = 1'b1;
      req_challenge = rand_ch();
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("hold_valid", rsp_valid, 1);
      check_val("hold_ones", rsp_ones, ones);
      check_val("hold_bit", rsp_bit, ebit);
      check_val("hold_stable", rsp_stable, estable);
      check_val("hold_ready", req_ready, 0);
      check_val("hold_sel", puf_sel, ch);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_val("hs_valid_drop", rsp_valid, 0);
    check_val("hs_req_ready", req_ready, 1);
    check_val("hs_sel", puf_sel, ch);
    $display("txn %0d ch=%h pat=%b ones=%0d bit=%0d stable=%0d hold=%0d", n_txn, ch, pat,
             rsp_ones, ebit, estable, hold);
    n_txn++;
  endtask

  initial begin
    logic [N-1:0] ch_a5;
    for (int i = 0; i < N / 8; i++) ch_a5[i*8 +: 8] = 8'hA5;

    // Power-on reset
    #2 reset = 1'b0;
    #1;
    check_val("rst_puf_in", puf_in, 0);
    check_val("rst_puf_rst", puf_rst, 1);
    check_val("rst_sel", puf_sel, 0);
    check_val("rst_valid", rsp_valid, 0);
    check_val("rst_ready", req_ready, 0);
    check_val("rst_ones", rsp_ones, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_val("rel_ready_before", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check_val("rel_ready_after", req_ready, 1);

    run_txn(ch_a5, 5'b11111, 0, 1'b0);
    run_txn(rand_ch(), 5'b00101, 10, 1'b0);
    run_txn(rand_ch(), 5'b01110, 0, 1'b1);
    // Back-to-back with rsp_ready held high
    run_txn(rand_ch(), 5'b00000, 0, 1'b0);
    run_txn(rand_ch(), 5'b10011, 0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      run_txn(rand_ch(), VOTES'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    // Abort in the middle of SETTLE
    rsp_ready     = 1'b0;
    pat_g         = '1;
    req_valid     = 1'b1;
    req_challenge = rand_ch();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("mid_puf_in", puf_in, 1);
    #2 reset = 1'b0;
    #1;
    check_val("abort_puf_in", puf_in, 0);
    check_val("abort_puf_rst", puf_rst, 1);
    check_val("abort_sel", puf_sel, 0);
    check_val("abort_valid", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_ready", req_ready, 1);
    repeat (LAT + 5) @(negedge clk);
    check_val("abort_no_rsp", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
